unidade_controle_multiciclo: RTL and testbench
==============================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as always 1.
REQ-002 SHALL have parameter ALU_CTRL_W, default 4, meaning width of alu_control.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port opcode, input, 7, opcode field of the instruction register.
REQ-007 SHALL have ports funct3 (input, 3) and funct7 (input, 7), the instruction register function fields.
REQ-008 SHALL have port zero, input, 1, ALU zero flag.
REQ-009 SHALL have port mem_ready, input, 1, memory handshake completion.
REQ-010 SHALL have outputs PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg, each 1 bit, as write and read strobes.
REQ-011 SHALL have output ALUSrcA, 2 bits: 00 PC, 01 oldPC, 10 rs1.
REQ-012 SHALL have output ALUSrcB, 2 bits: 00 rs2, 01 constant 4, 10 imm.
REQ-013 SHALL have output PCSrc, 1 bit: 0 ALU result, 1 ALUOut register.
REQ-014 SHALL have output alu_control, ALU_CTRL_W bits, ALU command.
REQ-015 SHALL have outputs state (3 bits, current state for debug) and illegal_instr (1 bit, sticky trap flag).

Function
REQ-016 SHALL implement a registered-state Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILLEGAL=5; outputs SHALL decode from state, opcode, funct3, funct7 and zero only.
REQ-017 FETCH: MemRead=1, ALUSrcA=00, ALUSrcB=01, ADD; IRWrite=PCWrite=mem_ready; SHALL go to DECODE on mem_ready, else hold.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=10, ADD, giving the branch target into ALUOut; SHALL go to EXEC if legal, else ILLEGAL.
REQ-019 Legal instructions: R 0110011 with add/sub (f3 000, f7 0000000/0100000), or (110), srl (101, f7 0); I 0010011 with addi 000, ori 110, andi 111, srli 101 (f7 0); lh 0000011 f3 001; sh 0100011 f3 001; beq 1100011 f3 000.
REQ-020 EXEC R/I: ALUSrcA=10, ALUSrcB=00 (R) or 10 (I), operation per funct; SHALL go to WB.
REQ-021 EXEC lh/sh: ALUSrcA=10, ALUSrcB=10, ADD; SHALL go to MEM.
REQ-022 EXEC beq: ALUSrcA=10, ALUSrcB=00, SUB, PCSrc=1, PCWrite=zero; SHALL go to FETCH.
REQ-023 MEM lh: MemRead=1, hold until mem_ready, then WB; sh: MemWrite=1, hold until mem_ready, then FETCH.
REQ-024 WB: RegWrite=1, MemToReg=1 only for lh; SHALL go to FETCH.
REQ-025 ILLEGAL: illegal_instr=1, all strobes 0, terminal until reset.
REQ-026 With mem_ready=1, latency SHALL be beq 3, R/I 4, sh 4, lh 5 cycles; each mem_ready=0 cycle in FETCH or MEM SHALL add exactly one cycle.
REQ-027 ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0100, SRL 0101; unused states SHALL drive ADD.
REQ-028 An undefined state encoding SHALL go to FETCH next cycle with all strobes 0.

Reset
REQ-029 While reset=1, every strobe and illegal_instr SHALL be 0 combinationally; at the edge, state SHALL become FETCH.
REQ-030 Reset mid-MEM SHALL abort the access, with no MemWrite in the cycle after the reset edge besides FETCH's MemRead.

Structure
REQ-031 A shared package SHALL hold opcode constants, ALU command constants and the state encoding.
REQ-032 ALU command decoding SHALL live in sub-module decodificador_ula (inputs class, funct3, funct7; output alu_control).

Verification
REQ-033 sub x3,x1,x2 (f7 0100000), mem_ready=1 -> states 0,1,2,4; alu_control=0100 in EXEC; RegWrite=1 only in cycle 4.
REQ-034 lh with mem_ready low 3 cycles in MEM -> MEM held 3 extra cycles, MemRead=1 throughout, WB MemToReg=1, 8 cycles total.
REQ-035 beq zero=1 -> PCWrite=1, PCSrc=1 in EXEC; zero=0 -> PCWrite=0; both return to FETCH at cycle 4.
REQ-036 opcode 1111111 -> ILLEGAL after DECODE, illegal_instr=1 held 10 cycles; reset -> FETCH, flag 0.
REQ-037 Reset asserted during sh MEM with mem_ready=0 -> MemWrite 0 same cycle, state 0 next cycle.
REQ-038 MEM_WAIT_EN=0 with mem_ready tied 0 -> lh completes in 5 cycles.

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU commands,
// FSM state encoding and the instruction legality/class decoder.
package unidade_controle_multiciclo_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ILLEGAL = 3'd5
  } state_t;

  // CL_NONE doubles as "illegal" during DECODE and "no ALU op" elsewhere
  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_R      = 3'd1,
    CL_I      = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5
  } iclass_t;

  // Classify the instruction register fields; anything outside the
  // supported subset returns CL_NONE.
  function automatic iclass_t classify(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [6:0] f7);
    iclass_t c;
    c = CL_NONE;
    case (op)
      OP_R:
        if ((f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
            ((f3 == 3'b110 || f3 == 3'b101) && f7 == 7'b0000000))
          c = CL_R;
      OP_I:
        if (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111 ||
            (f3 == 3'b101 && f7 == 7'b0000000))
          c = CL_I;
      OP_LOAD:   if (f3 == 3'b001) c = CL_LOAD;
      OP_STORE:  if (f3 == 3'b001) c = CL_STORE;
      OP_BRANCH: if (f3 == 3'b000) c = CL_BRANCH;
      default:   c = CL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_ula.sv
// ALU command decoder: maps instruction class and function fields to the
// ALU command. Non-ALU classes (CL_NONE) fall back to ADD.
module decodificador_ula
  import unidade_controle_multiciclo_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [2:0]            instr_class,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] cmd;

  // Command selection; immediate ops never subtract, so only R uses funct7
  always_comb begin
    cmd = ALU_ADD;
    case (instr_class)
      CL_R:
        case (funct3)
          3'b000:  cmd = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b110:  cmd = ALU_OR;
          3'b111:  cmd = ALU_AND;
          3'b101:  cmd = ALU_SRL;
          default: cmd = ALU_ADD;
        endcase
      CL_I:
        case (funct3)
          3'b110:  cmd = ALU_OR;
          3'b111:  cmd = ALU_AND;
          3'b101:  cmd = ALU_SRL;
          default: cmd = ALU_ADD;
        endcase
      CL_BRANCH: cmd = ALU_SUB;
      default:   cmd = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(cmd);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RISC-V subset control unit: registered-state Moore FSM
// (FETCH/DECODE/EXEC/MEM/WB/ILLEGAL) with outputs decoded from the state
// and the instruction register fields.
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemToReg,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  PCSrc,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            state,
  output logic                  illegal_instr
);

  state_t  state_q, state_d;
  iclass_t cls, alu_cls;
  logic    rdy;

  assign cls     = classify(opcode, funct3, funct7);
  assign rdy     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign alu_cls = (state_q == S_EXEC) ? cls : CL_NONE;
  assign state   = state_q;

  // Next-state selection; undefined encodings recover to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (rdy) state_d = S_DECODE;
      S_DECODE:  state_d = (cls == CL_NONE) ? S_ILLEGAL : S_EXEC;
      S_EXEC:
        case (cls)
          CL_R, CL_I:        state_d = S_WB;
          CL_LOAD, CL_STORE: state_d = S_MEM;
          default:           state_d = S_FETCH;
        endcase
      S_MEM:     if (rdy) state_d = (cls == CL_LOAD) ? S_WB : S_FETCH;
      S_WB:      state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode; reset masks every strobe immediately so an aborted
  // memory access never sees a write in the reset cycle
  always_comb begin
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemToReg      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    PCSrc         = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCWrite = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_EXEC: begin
        ALUSrcA = 2'b10;
        case (cls)
          CL_I, CL_LOAD, CL_STORE: ALUSrcB = 2'b10;
          CL_BRANCH: begin
            ALUSrcB = 2'b00;
            PCSrc   = 1'b1;
            PCWrite = zero;
          end
          default:                 ALUSrcB = 2'b00;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls == CL_LOAD);
        MemWrite = (cls == CL_STORE);
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = (cls == CL_LOAD);
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemToReg      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  decodificador_ula #(.ALU_CTRL_W(ALU_CTRL_W)) u_dec (
    .instr_class (alu_cls),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control unit. Each instruction is expanded into
// its expected per-cycle output script from the instruction's mnemonic.
module tb_unidade_controle_multiciclo;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mrd, mwr, m2r;
    logic [1:0] sa, sb;
    logic       pcs;
    logic [3:0] alu;
    logic       ill;
  } cyc_t;

  typedef enum int {M_ADD, M_SUB, M_OR, M_SRL, M_ADDI, M_ORI, M_ANDI, M_SRLI,
                    M_LH, M_SH, M_BEQ, M_ILL} mn_t;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0100;
  localparam logic [3:0] A_SRL = 4'b0101;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       pcw0, irw0, rw0, mrd0, mwr0, m2r0, pcs0, ill0;
  logic [1:0] sa0, sb0;
  logic [3:0] alu0;
  logic [2:0] st0;
  logic       pcw1, irw1, rw1, mrd1, mwr1, m2r1, pcs1, ill1;
  logic [1:0] sa1, sb1;
  logic [3:0] alu1;
  logic [2:0] st1;
  cyc_t       o0, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign o0 = {st0, pcw0, irw0, rw0, mrd0, mwr0, m2r0, sa0, sb0, pcs0, alu0, ill0};
  assign o1 = {st1, pcw1, irw1, rw1, mrd1, mwr1, m2r1, sa1, sb1, pcs1, alu1, ill1};

  unidade_controle_multiciclo #(.MEM_WAIT_EN(1), .ALU_CTRL_W(4)) u0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemRead(mrd0), .MemWrite(mwr0),
    .MemToReg(m2r0), .ALUSrcA(sa0), .ALUSrcB(sb0), .PCSrc(pcs0),
    .alu_control(alu0), .state(st0), .illegal_instr(ill0));

  unidade_controle_multiciclo #(.MEM_WAIT_EN(0), .ALU_CTRL_W(4)) u1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(1'b0),
    .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1), .MemRead(mrd1), .MemWrite(mwr1),
    .MemToReg(m2r1), .ALUSrcA(sa1), .ALUSrcB(sb1), .PCSrc(pcs1),
    .alu_control(alu1), .state(st1), .illegal_instr(ill1));

  // strobes order: {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg}
  function automatic cyc_t mk(input logic [2:0] st, input logic [5:0] s6,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic pcs, input logic [3:0] alu, input logic ill);
    return {st, s6, sa, sb, pcs, alu, ill};
  endfunction

  // care = {state, ALUSrcA, ALUSrcB, PCSrc}; strobes/alu/flag always compared
  function automatic cyc_t mask(input logic [3:0] care);
    cyc_t m;
    m = '1;
    if (!care[3]) m.st  = '0;
    if (!care[2]) m.sa  = '0;
    if (!care[1]) m.sb  = '0;
    if (!care[0]) m.pcs = 1'b0;
    return m;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] exp_alu(input mn_t mn);
    case (mn)
      M_SUB, M_BEQ:   return A_SUB;
      M_OR, M_ORI:    return A_OR;
      M_ANDI:         return A_AND;
      M_SRL, M_SRLI:  return A_SRL;
      default:        return A_ADD;
    endcase
  endfunction

  task automatic step(input cyc_t e, input logic [3:0] care, input logic mr,
                      input logic rst, input string tag, input bit dut = 1'b0);
    cyc_t o, m;
    mem_ready = mr;
    reset     = rst;
    @(negedge clk);
    o = dut ? o1 : o0;
    m = mask(care);
    checks++;
    assert ((o & m) === (e & m)) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input mn_t mn, input int ill_idx);
    logic [6:0] r7;
    r7 = 7'($urandom);
    case (mn)
      M_ADD:  {opcode, funct3, funct7} = {7'b0110011, 3'b000, 7'b0000000};
      M_SUB:  {opcode, funct3, funct7} = {7'b0110011, 3'b000, 7'b0100000};
      M_OR:   {opcode, funct3, funct7} = {7'b0110011, 3'b110, 7'b0000000};
      M_SRL:  {opcode, funct3, funct7} = {7'b0110011, 3'b101, 7'b0000000};
      M_ADDI: {opcode, funct3, funct7} = {7'b0010011, 3'b000, r7};
      M_ORI:  {opcode, funct3, funct7} = {7'b0010011, 3'b110, r7};
      M_ANDI: {opcode, funct3, funct7} = {7'b0010011, 3'b111, r7};
      M_SRLI: {opcode, funct3, funct7} = {7'b0010011, 3'b101, 7'b0000000};
      M_LH:   {opcode, funct3, funct7} = {7'b0000011, 3'b001, r7};
      M_SH:   {opcode, funct3, funct7} = {7'b0100011, 3'b001, r7};
      M_BEQ:  {opcode, funct3, funct7} = {7'b1100011, 3'b000, r7};
      default:
        case (ill_idx)
          0: {opcode, funct3, funct7} = {7'b1111111, 3'($urandom), r7};
          1: {opcode, funct3, funct7} = {7'b0110011, 3'b111, 7'b0000000};
          2: {opcode, funct3, funct7} = {7'b0110011, 3'b000, 7'b0000001};
          3: {opcode, funct3, funct7} = {7'b0010011, 3'b001, 7'b0000000};
          4: {opcode, funct3, funct7} = {7'b0000011, 3'b010, r7};
          5: {opcode, funct3, funct7} = {7'b0100011, 3'b010, r7};
          6: {opcode, funct3, funct7} = {7'b1100011, 3'b001, r7};
          7: {opcode, funct3, funct7} = {7'b0110011, 3'b101, 7'b0100000};
          8: {opcode, funct3, funct7} = {7'b0010011, 3'b101, 7'b0100000};
          default: {opcode, funct3, funct7} = {7'b0110111, 3'($urandom), r7};
        endcase
    endcase
  endtask

  // One instruction from FETCH to its return to FETCH (or to a reset).
  task automatic run_instr(input mn_t mn, input int ill_idx, input logic z,
                           input int nwf, input int nwm, input int nill,
                           input bit rst_mem);
    logic is_lh, is_sh;
    is_lh = (mn == M_LH);
    is_sh = (mn == M_SH);
    set_fields(mn, ill_idx);
    zero = z;
    repeat (nwf) step(mk(3'd0, 6'b000100, 2'd0, 2'd1, 1'b0, A_ADD, 1'b0), 4'b1111, 1'b0, 1'b0, "fetch_wait");
    step(mk(3'd0, 6'b110100, 2'd0, 2'd1, 1'b0, A_ADD, 1'b0), 4'b1111, 1'b1, 1'b0, "fetch");
    step(mk(3'd1, 6'b000000, 2'd1, 2'd2, 1'b0, A_ADD, 1'b0), 4'b1110, rb(), 1'b0, "decode");
    if (mn == M_ILL) begin
      repeat (nill) step(mk(3'd5, 6'b000000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b1), 4'b1000, rb(), 1'b0, "illegal_hold");
      step(mk(3'd5, 6'b000000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, rb(), 1'b1, "illegal_reset");
      return;
    end
    if (mn inside {M_ADD, M_SUB, M_OR, M_SRL, M_ADDI, M_ORI, M_ANDI, M_SRLI}) begin
      step(mk(3'd2, 6'b000000, 2'd2, (mn inside {M_ADD, M_SUB, M_OR, M_SRL}) ? 2'd0 : 2'd2,
              1'b0, exp_alu(mn), 1'b0), 4'b1110, rb(), 1'b0, "exec_alu");
      step(mk(3'd4, 6'b001000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, rb(), 1'b0, "wb_alu");
    end else if (is_lh || is_sh) begin
      step(mk(3'd2, 6'b000000, 2'd2, 2'd2, 1'b0, A_ADD, 1'b0), 4'b1110, rb(), 1'b0, "exec_mem");
      repeat (nwm) step(mk(3'd3, {3'b000, is_lh, is_sh, 1'b0}, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0),
                        4'b1000, 1'b0, 1'b0, "mem_wait");
      if (rst_mem) begin
        step(mk(3'd3, 6'b000000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b0, 1'b1, "mem_reset");
        return;
      end
      step(mk(3'd3, {3'b000, is_lh, is_sh, 1'b0}, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b1, 1'b0, "mem");
      if (is_lh)
        step(mk(3'd4, 6'b001001, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, rb(), 1'b0, "wb_lh");
    end else begin
      step(mk(3'd2, {z, 5'b00000}, 2'd2, 2'd0, 1'b1, A_SUB, 1'b0), 4'b1111, rb(), 1'b0, "exec_beq");
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    @(posedge clk); #1;
    // reset held: FETCH with every strobe masked
    step(mk(3'd0, 6'b000000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b0, 1'b1, "reset_state");

    // no-wait instance: lh completes in 5 cycles with mem_ready tied low
    set_fields(M_LH, 0);
    step(mk(3'd0, 6'b110100, 2'd0, 2'd1, 1'b0, A_ADD, 1'b0), 4'b1111, 1'b0, 1'b0, "nowait_fetch", 1'b1);
    step(mk(3'd1, 6'b000000, 2'd1, 2'd2, 1'b0, A_ADD, 1'b0), 4'b1110, 1'b0, 1'b0, "nowait_decode", 1'b1);
    step(mk(3'd2, 6'b000000, 2'd2, 2'd2, 1'b0, A_ADD, 1'b0), 4'b1110, 1'b0, 1'b0, "nowait_exec", 1'b1);
    step(mk(3'd3, 6'b000100, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b0, 1'b0, "nowait_mem", 1'b1);
    step(mk(3'd4, 6'b001001, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b0, 1'b0, "nowait_wb", 1'b1);
    step(mk(3'd0, 6'b110100, 2'd0, 2'd1, 1'b0, A_ADD, 1'b0), 4'b1111, 1'b0, 1'b0, "nowait_refetch", 1'b1);
    // main instance sat in FETCH waiting throughout; resync both
    step(mk(3'd0, 6'b000000, 2'd0, 2'd0, 1'b0, A_ADD, 1'b0), 4'b1000, 1'b0, 1'b1, "resync_reset");

    run_instr(M_SUB, 0, 1'b0, 0, 0, 0, 1'b0);
    run_instr(M_LH,  0, 1'b0, 0, 3, 0, 1'b0);
    run_instr(M_BEQ, 0, 1'b1, 0, 0, 0, 1'b0);
    run_instr(M_BEQ, 0, 1'b0, 0, 0, 0, 1'b0);
    run_instr(M_ILL, 0, 1'b0, 0, 0, 10, 1'b0);
    run_instr(M_SH,  0, 1'b0, 0, 1, 0, 1'b1);
    run_instr(M_ADD, 0, 1'b0, 1, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      run_instr(mn_t'($urandom_range(0, 11)), int'($urandom_range(0, 9)), rb(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)), 1'b0);
    step(mk(3'd0, 6'b000100, 2'd0, 2'd1, 1'b0, A_ADD, 1'b0), 4'b1111, 1'b0, 1'b0, "final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
